// File: rtl/fb_pkg.sv
// Shared frame buffer definitions: register map, FSM encoding, field widths.
// Used by the write scheduler and the VGA interface logic.
package fb_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  localparam logic [7:0] A_Y0  = 8'hB0;
  localparam logic [7:0] A_X0  = 8'hB1;
  localparam logic [7:0] A_PIX = 8'hB2;
  localparam logic [7:0] A_X1  = 8'hB3;
  localparam logic [7:0] A_Y1  = 8'hB4;
  localparam logic [7:0] A_CMD = 8'hB5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fb_state_e;

  function automatic logic [X_W-1:0] clamp_x(
    input logic [X_W-1:0] v,
    input logic [X_W-1:0] m
  );
    return (v > m) ? m : v;
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(
    input logic [Y_W-1:0] v,
    input logic [Y_W-1:0] m
  );
    return (v > m) ? m : v;
  endfunction

endpackage

// File: rtl/fb_write_scheduler_cursor.sv
// Raster cursor for the fill engine: X inner, Y outer, holds on stall.
// Bounds are captured on load so later register writes cannot disturb a fill.
module fb_raster_cursor
  import fb_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [X_W-1:0] i_x0,
  input  logic [X_W-1:0] i_x1,
  input  logic [Y_W-1:0] i_y0,
  input  logic [Y_W-1:0] i_y1,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] r_x0;
  logic [X_W-1:0] r_x1;
  logic [Y_W-1:0] r_y1;
  logic           w_eol;
  logic           w_last;

  assign w_eol  = (r_x == r_x1);
  assign w_last = w_eol && (r_y == r_y1);

  // Load bounds at start, then advance one pixel per granted step.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_x  <= '0;
      r_y  <= '0;
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
    end else if (i_load) begin
      r_x  <= i_x0;
      r_y  <= i_y0;
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
    end else if (i_step && !w_last) begin
      if (w_eol) begin
        r_x <= r_x0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_last;

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame buffer write scheduler: bus register decode, direct pixel path, fill FSM.
// Define FB_FILL_IRQ_EN to add the FILL_DONE_IRQ output.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  DATA,
  input  logic        BUS_WE,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic        BUSY
`ifdef FB_FILL_IRQ_EN
  ,
  output logic        FILL_DONE_IRQ
`endif
);

  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);

  fb_state_e      r_state;
  fb_state_e      w_state_nxt;
  logic [X_W-1:0] r_x0;
  logic [X_W-1:0] r_x1;
  logic [Y_W-1:0] r_y0;
  logic [Y_W-1:0] r_y1;
  logic           r_col;
  logic [14:0]    r_fb_addr;
  logic           r_fb_data;
  logic           r_fb_we;

  logic           w_pix;
  logic           w_start;
  logic           w_degen;
  logic [X_W-1:0] w_x1c;
  logic [Y_W-1:0] w_y1c;
  logic           w_busy;
  logic           w_fill_step;
  logic [X_W-1:0] w_cx;
  logic [Y_W-1:0] w_cy;
  logic           w_last;

  assign w_pix   = BUS_WE && (ADDRESS == A_PIX);
  assign w_start = BUS_WE && (ADDRESS == A_CMD) && DATA[1]
                   && (r_state == ST_IDLE);
  assign w_x1c   = clamp_x(r_x1, XM);
  assign w_y1c   = clamp_y(r_y1, YM);
  assign w_degen = (r_x0 > w_x1c) || (r_y0 > w_y1c);

  // Coordinate registers take bus writes in any state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_y0 <= '0;
      r_y1 <= '0;
    end else if (BUS_WE) begin
      unique case (1'b1)
        ADDRESS == A_Y0: r_y0 <= DATA[Y_W-1:0];
        ADDRESS == A_X0: r_x0 <= DATA;
        ADDRESS == A_X1: r_x1 <= DATA;
        ADDRESS == A_Y1: r_y1 <= DATA[Y_W-1:0];
        default: ;
      endcase
    end
  end

  // Fill colour is captured only by an accepted start.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_col <= 1'b0;
    end else if (w_start) begin
      r_col <= DATA[0];
    end
  end

  fb_raster_cursor u_cursor (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_load (w_start),
    .i_step (w_fill_step),
    .i_x0   (r_x0),
    .i_x1   (w_x1c),
    .i_y0   (r_y0),
    .i_y1   (w_y1c),
    .o_x    (w_cx),
    .o_y    (w_cy),
    .o_last (w_last)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = w_degen ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_fill_step && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; a direct pixel stalls the fill for one cycle.
  always_comb begin
    w_busy      = 1'b0;
    w_fill_step = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        w_busy      = 1'b1;
        w_fill_step = !w_pix;
      end
      ST_DONE: w_busy = 1'b1;
      default: ;
    endcase
  end

  // Frame buffer port: direct pixel wins, otherwise the fill cursor.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_fb_addr <= '0;
      r_fb_data <= 1'b0;
      r_fb_we   <= 1'b0;
    end else if (w_pix) begin
      r_fb_addr <= {r_y0, r_x0};
      r_fb_data <= DATA[0];
      r_fb_we   <= 1'b1;
    end else if (w_fill_step) begin
      r_fb_addr <= {w_cy, w_cx};
      r_fb_data <= r_col;
      r_fb_we   <= 1'b1;
    end else begin
      r_fb_we   <= 1'b0;
    end
  end

  assign FB_ADDR = r_fb_addr;
  assign FB_DATA = r_fb_data;
  assign FB_WE   = r_fb_we;
  assign BUSY    = w_busy;

`ifdef FB_FILL_IRQ_EN
  assign FILL_DONE_IRQ = (r_state == ST_DONE);
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: vector table plus fill sequences.
// Expected values are hand-computed from the register map and fill rules.
module tb_fb_write_scheduler;

  logic        CLK;
  logic        RESET;
  logic [7:0]  ADDRESS;
  logic [7:0]  DATA;
  logic        BUS_WE;
  logic [14:0] FB_ADDR;
  logic        FB_DATA;
  logic        FB_WE;
  logic        BUSY;
`ifdef FB_FILL_IRQ_EN
  logic        FILL_DONE_IRQ;
`endif

  int total = 0;
  int bad   = 0;

  fb_write_scheduler dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ADDRESS (ADDRESS),
    .DATA    (DATA),
    .BUS_WE  (BUS_WE),
    .FB_ADDR (FB_ADDR),
    .FB_DATA (FB_DATA),
    .FB_WE   (FB_WE),
    .BUSY    (BUSY)
`ifdef FB_FILL_IRQ_EN
    ,
    .FILL_DONE_IRQ (FILL_DONE_IRQ)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [7:0]  a;
    logic [7:0]  d;
    logic        ewe;
    logic        ebusy;
    logic [14:0] eaddr;
    logic        edata;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [7:0] a,
                     input logic [7:0] d);
    ADDRESS = a;
    DATA    = d;
    BUS_WE  = we;
    @(posedge CLK);
    #1;
    BUS_WE  = 1'b0;
  endtask

  task automatic fill_run(
    input  logic [7:0]  mx0, my0, mx1,
    input  logic [7:0]  cmd,
    input  int          inj_c,
    input  logic [7:0]  ia, id,
    input  logic [14:0] ida,
    input  int          maxc,
    output int          n_wr, n_busy, n_ord,
    output logic [14:0] last_a
  );
    logic [7:0] ex, ey;
    logic       pix;
    bit         done;
    n_wr = 0; n_busy = 0; n_ord = 0; last_a = '0;
    ex = mx0; ey = my0; done = 0;
    for (int c = 0; c < maxc && !done; c++) begin
      pix = (c == inj_c) && (ia == 8'hB2);
      if (c == 0) cyc(1'b1, 8'hB5, cmd);
      else if (c == inj_c) cyc(1'b1, ia, id);
      else cyc(1'b0, 8'h00, 8'h00);
      if (BUSY) n_busy++;
      if (FB_WE && pix) begin
        if (FB_ADDR !== ida || FB_DATA !== id[0]) n_ord++;
      end else if (FB_WE) begin
        n_wr++;
        last_a = FB_ADDR;
        if (FB_ADDR !== {ey[6:0], ex} || FB_DATA !== cmd[0]) n_ord++;
        if (ex == mx1) begin
          ex = mx0;
          ey = ey + 8'd1;
        end else begin
          ex = ex + 8'd1;
        end
      end else if (pix) begin
        n_ord++;
      end
      if (c > 0 && !BUSY && !FB_WE) done = 1;
    end
    chk("fill_terminates", 32'(done), 32'd1);
  endtask

  int          n_wr, n_busy, n_ord, seen;
  logic [14:0] last_a;

  initial begin
    tv[0]  = '{1'b1, 8'hB0, 8'h05, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[1]  = '{1'b1, 8'hB1, 8'h0A, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[2]  = '{1'b1, 8'hB2, 8'h01, 1'b1, 1'b0, 15'h050A, 1'b1};
    tv[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[4]  = '{1'b1, 8'hB0, 8'h04, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[5]  = '{1'b1, 8'hB1, 8'h03, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[6]  = '{1'b1, 8'hB3, 8'h04, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[7]  = '{1'b1, 8'hB4, 8'h05, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[8]  = '{1'b1, 8'hB5, 8'h03, 1'b0, 1'b1, 15'h0000, 1'b0};
    tv[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 15'h0403, 1'b1};
    tv[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 15'h0404, 1'b1};
    tv[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 15'h0503, 1'b1};
    tv[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 15'h0504, 1'b1};
    tv[13] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[14] = '{1'b1, 8'hB1, 8'h0A, 1'b0, 1'b0, 15'h0000, 1'b0};
    tv[15] = '{1'b1, 8'hB5, 8'h02, 1'b0, 1'b1, 15'h0000, 1'b0};
    tv[16] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 15'h0000, 1'b0};

    RESET = 1'b0; ADDRESS = '0; DATA = '0; BUS_WE = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_we",   32'(FB_WE),   32'd0);
    chk("rst_busy", 32'(BUSY),    32'd0);
    chk("rst_addr", 32'(FB_ADDR), 32'd0);
    chk("rst_data", 32'(FB_DATA), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // direct write, 2x2 fill, degenerate fill
    for (int i = 0; i < 17; i++) begin
      cyc(tv[i].we, tv[i].a, tv[i].d);
      chk($sformatf("vec%0d_we", i),   32'(FB_WE), 32'(tv[i].ewe));
      chk($sformatf("vec%0d_busy", i), 32'(BUSY),  32'(tv[i].ebusy));
      if (tv[i].ewe) begin
        chk($sformatf("vec%0d_addr", i), 32'(FB_ADDR), 32'(tv[i].eaddr));
        chk($sformatf("vec%0d_data", i), 32'(FB_DATA), 32'(tv[i].edata));
      end
    end

    // collision: direct pixel mid-fill
    cyc(1'b1, 8'hB1, 8'h03);
    fill_run(8'd3, 8'd4, 8'd4, 8'h03, 2, 8'hB2, 8'h00, 15'h0403, 50,
             n_wr, n_busy, n_ord, last_a);
    chk("coll_writes", 32'(n_wr),   32'd4);
    chk("coll_busy",   32'(n_busy), 32'd6);
    chk("coll_order",  32'(n_ord),  32'd0);
    chk("coll_last",   32'(last_a), 32'h0504);

    // second start during fill is ignored
    fill_run(8'd3, 8'd4, 8'd4, 8'h03, 2, 8'hB5, 8'h02, 15'h0000, 50,
             n_wr, n_busy, n_ord, last_a);
    chk("restart_writes", 32'(n_wr),   32'd4);
    chk("restart_busy",   32'(n_busy), 32'd5);
    chk("restart_order",  32'(n_ord),  32'd0);

    // bound register rewritten mid-fill does not affect it
    fill_run(8'd3, 8'd4, 8'd4, 8'h03, 1, 8'hB3, 8'h00, 15'h0000, 50,
             n_wr, n_busy, n_ord, last_a);
    chk("rewr_writes", 32'(n_wr),  32'd4);
    chk("rewr_order",  32'(n_ord), 32'd0);

    // clear screen with clamped bounds
    cyc(1'b1, 8'hB0, 8'h00);
    cyc(1'b1, 8'hB1, 8'h00);
    cyc(1'b1, 8'hB3, 8'hFF);
    cyc(1'b1, 8'hB4, 8'h7F);
    fill_run(8'd0, 8'd0, 8'd159, 8'h02, -1, 8'h00, 8'h00, 15'h0000, 20000,
             n_wr, n_busy, n_ord, last_a);
    chk("clr_writes", 32'(n_wr),   32'd19200);
    chk("clr_busy",   32'(n_busy), 32'd19201);
    chk("clr_order",  32'(n_ord),  32'd0);
    chk("clr_last",   32'(last_a), 32'h779F);

    // reset at pixel 7 of a 4x3 fill
    cyc(1'b1, 8'hB0, 8'h01);
    cyc(1'b1, 8'hB1, 8'h02);
    cyc(1'b1, 8'hB3, 8'h05);
    cyc(1'b1, 8'hB4, 8'h03);
    cyc(1'b1, 8'hB5, 8'h03);
    seen = 0;
    for (int c = 0; c < 40 && seen < 7; c++) begin
      cyc(1'b0, 8'h00, 8'h00);
      if (FB_WE) seen++;
    end
    chk("rst_mid_seen7", 32'(seen), 32'd7);
    #2;
    RESET = 1'b0;
    #1;
    chk("rst_mid_we",   32'(FB_WE),   32'd0);
    chk("rst_mid_busy", 32'(BUSY),    32'd0);
    chk("rst_mid_addr", 32'(FB_ADDR), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    n_wr = 0; n_busy = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b0, 8'h00, 8'h00);
      if (FB_WE) n_wr++;
      if (BUSY) n_busy++;
    end
    chk("post_rst_writes", 32'(n_wr),   32'd0);
    chk("post_rst_busy",   32'(n_busy), 32'd0);
    cyc(1'b1, 8'hB2, 8'h01);
    chk("post_rst_pix_we",   32'(FB_WE),   32'd1);
    chk("post_rst_pix_addr", 32'(FB_ADDR), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port ADDRESS  input  8  bus address.
REQ-004 SHALL have port DATA  input  8  bus write data.
REQ-005 SHALL have port BUS_WE  input  1  bus write strobe, one cycle per write.
REQ-006 SHALL have port FB_ADDR  output  15  frame buffer port-A address; [14:8]=Y, [7:0]=X.
REQ-007 SHALL have port FB_DATA  output  1  frame buffer pixel value.
REQ-008 SHALL have port FB_WE  output  1  frame buffer write enable.
REQ-009 SHALL have port BUSY  output  1  fill engine active.
REQ-010 SHALL have parameters X_MAX, default 159, last valid column; Y_MAX, default 119, last valid row.

Function
REQ-011 SHALL decode bus writes: 0xB0 Y0 (DATA[6:0]); 0xB1 X0; 0xB2 direct pixel (DATA[0]); 0xB3 X1; 0xB4 Y1 (DATA[6:0]); 0xB5 command (bit0 fill colour, bit1 start).
REQ-012 SHALL, on a 0xB2 write, present FB_ADDR={Y0,X0}, FB_DATA=DATA[0], FB_WE=1 in the next cycle, for exactly one cycle.
REQ-013 SHALL drive all FB_* outputs from registers; FB_WE SHALL be 0 in every cycle with no scheduled write.
REQ-014 SHALL implement states IDLE, FILL and DONE.
REQ-015 SHALL, in IDLE, on a 0xB5 write with bit1=1: latch the colour; clamp X1 to X_MAX and Y1 to Y_MAX; load cursor (X0,Y0); enter FILL; assert BUSY from the next cycle.
REQ-016 SHALL, in FILL, emit one pixel per cycle in raster order (X increments inner, Y outer) over the inclusive rectangle X0..X1, Y0..Y1.
REQ-017 SHALL move from FILL to DONE on the cycle it registers the last pixel, then from DONE to IDLE one cycle later; BUSY SHALL be 0 in IDLE.
REQ-018 SHALL give a W x H rectangle W*H fill writes and W*H+1 BUSY cycles when no stalls occur.
REQ-019 SHALL treat X0>X1 or Y0>Y1 after clamping as degenerate: go IDLE->DONE->IDLE, perform zero writes, and hold BUSY for one cycle.
REQ-020 SHALL give direct 0xB2 writes priority over the fill engine: in a collision cycle the direct pixel is issued, the fill cursor holds, and the fill resumes next cycle with no pixel lost.
REQ-021 SHALL ignore start commands while in FILL or DONE; 0xB0, 0xB1, 0xB3 and 0xB4 writes during FILL SHALL update the registers without affecting the fill in progress (bounds are latched at start).
REQ-022 SHALL hold the cursor width to the field width, with no wrap past X1 or Y1.

Reset
REQ-023 SHALL, while RESET=0, immediately force state IDLE, FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0, and all coordinate and colour registers to 0.
REQ-024 SHALL abandon a fill interrupted by reset without resuming it; the first write after release SHALL come only from new bus activity.

Configuration
REQ-025 SHALL, with FB_FILL_IRQ_EN defined, add output FILL_DONE_IRQ (1 bit), high for exactly the one DONE cycle of each fill, degenerate fills included, and 0 in reset.
REQ-026 SHALL, without FB_FILL_IRQ_EN, have no FILL_DONE_IRQ port and otherwise identical behaviour.

Structure
REQ-027 SHALL take the register addresses 0xB0-0xB5, the state encoding and the X/Y field widths from a shared package fb_pkg, also used by the VGA interface logic.
REQ-028 SHALL implement the raster cursor (X/Y counters, stall, last-pixel detect) as sub-module fb_raster_cursor; decode, arbitration and the FSM SHALL stay in the top module.

Verification
REQ-029 SHALL cover direct write: B0<-0x05, B1<-0x0A, B2<-0x01 -> one cycle later FB_ADDR=0x050A, FB_DATA=1, FB_WE=1 for one cycle.
REQ-030 SHALL cover a 2x2 fill: X0=3, Y0=4, X1=4, Y1=5, B5<-0x03 -> writes 0x0403, 0x0404, 0x0503, 0x0504 all with data 1, BUSY high 5 cycles.
REQ-031 SHALL cover clear screen: X0=Y0=0, X1=0xFF, Y1=0x7F, B5<-0x02 -> clamped to 159/119, 19200 writes with data 0, last address 0x779F.
REQ-032 SHALL cover a collision: B2 write mid-fill -> direct pixel issued that cycle, total fill writes unchanged, BUSY extended by 1 cycle.
REQ-033 SHALL cover degenerate and busy cases: X0=10, X1=5 start -> zero writes, BUSY 1 cycle; second start during FILL -> ignored.
REQ-034 SHALL cover reset mid-fill: RESET low at pixel 7 -> FB_WE=0 and BUSY=0 immediately, no writes after release.
